// File: rtl/dma_stream_arbiter_pkg.sv
// Shared DMA definitions: stream count, priority levels and arbiter state encoding.
package dma_pkg;

    localparam int unsigned N_STREAMS = 8;
    localparam int unsigned ID_W      = $clog2(N_STREAMS);
    localparam int unsigned N_LEVELS  = 4;

    typedef logic [1:0] prio_t;

    localparam prio_t PRIO_LOW   = 2'd0;
    localparam prio_t PRIO_MED   = 2'd1;
    localparam prio_t PRIO_HIGH  = 2'd2;
    localparam prio_t PRIO_VHIGH = 2'd3;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

endpackage

// File: rtl/dma_stream_arbiter_if.sv
// Request/grant bundle between stream control registers, master sequencer and the arbiter.
interface dma_stream_arbiter_if;
    import dma_pkg::*;

    logic [N_STREAMS-1:0]   i_req;
    logic [2*N_STREAMS-1:0] i_prio;
    logic                   i_done;
    logic [N_STREAMS-1:0]   o_grant;
    logic                   o_grant_valid;
    logic [ID_W-1:0]        o_grant_id;
    logic                   o_release;

    // Requester/sequencer side
    modport master (
        output i_req, i_prio, i_done,
        input  o_grant, o_grant_valid, o_grant_id, o_release
    );

    // Arbiter side
    modport slave (
        input  i_req, i_prio, i_done,
        output o_grant, o_grant_valid, o_grant_id, o_release
    );

endinterface

// File: rtl/dma_stream_arbiter_rr_pick.sv
// Combinational round-robin picker: first set mask bit at or after the start index, wrapping.
module dma_rr_pick
    import dma_pkg::*;
(
    input  logic [N_STREAMS-1:0] i_mask,
    input  logic [ID_W-1:0]      i_start,
    output logic                 o_found,
    output logic [ID_W-1:0]      o_id
);

    logic [ID_W-1:0] idx;

    always_comb begin
        o_found = 1'b0;
        o_id    = '0;
        idx     = '0;
        for (int unsigned i = 0; i < N_STREAMS; i++) begin
            // index arithmetic wraps naturally at ID_W bits
            idx = i_start + ID_W'(i);
            if (!o_found && i_mask[idx]) begin
                o_found = 1'b1;
                o_id    = idx;
            end
        end
    end

endmodule

// File: rtl/dma_stream_arbiter.sv
// Selects the stream owning the AHB master datapath: priority level first, round-robin within a level.
module dma_stream_arbiter
    import dma_pkg::*;
(
    input  logic                  i_hclk,
    input  logic                  i_hnreset,
    dma_stream_arbiter_if.slave   arb_if
);

    arb_state_t           state_q, state_d;
    logic [N_STREAMS-1:0] grant_q, grant_d;
    logic                 grant_valid_q, grant_valid_d;
    logic [ID_W-1:0]      grant_id_q, grant_id_d;
    logic                 release_q, release_d;
    prio_t                level_q, level_d;
    logic [ID_W-1:0]      rr_ptr_q [N_LEVELS];
    logic [ID_W-1:0]      rr_ptr_d [N_LEVELS];

    logic [N_STREAMS-1:0] lvl_mask  [N_LEVELS];
    logic                 lvl_found [N_LEVELS];
    logic [ID_W-1:0]      lvl_id    [N_LEVELS];

    logic                 win_found;
    logic [ID_W-1:0]      win_id;
    prio_t                win_level;
    logic                 withdraw;

    always_comb begin
        for (int unsigned p = 0; p < N_LEVELS; p++) begin
            lvl_mask[p] = '0;
            for (int unsigned k = 0; k < N_STREAMS; k++) begin
                lvl_mask[p][k] = arb_if.i_req[k] &&
                                 (prio_t'(arb_if.i_prio[2*k +: 2]) == prio_t'(p));
            end
        end
    end

    for (genvar p = 0; p < N_LEVELS; p++) begin : g_level
        dma_rr_pick u_pick (
            .i_mask  (lvl_mask[p]),
            .i_start (rr_ptr_q[p]),
            .o_found (lvl_found[p]),
            .o_id    (lvl_id[p])
        );
    end

    // Ascending scan so the highest level with a requester overrides lower ones
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        win_level = PRIO_LOW;
        for (int unsigned p = 0; p < N_LEVELS; p++) begin
            if (lvl_found[p]) begin
                win_found = 1'b1;
                win_id    = lvl_id[p];
                win_level = prio_t'(p);
            end
        end
    end

    assign withdraw = !arb_if.i_req[grant_id_q];

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        level_d       = level_q;
        release_d     = 1'b0;
        for (int unsigned p = 0; p < N_LEVELS; p++) begin
            rr_ptr_d[p] = rr_ptr_q[p];
        end

        unique case (state_q)
            ARB_IDLE: begin
                if (win_found) begin
                    state_d       = ARB_BUSY;
                    grant_d       = N_STREAMS'(1) << win_id;
                    grant_valid_d = 1'b1;
                    grant_id_d    = win_id;
                    level_d       = win_level;
                end
            end
            ARB_BUSY: begin
                if (arb_if.i_done || withdraw) begin
                    state_d           = ARB_IDLE;
                    grant_d           = '0;
                    grant_valid_d     = 1'b0;
                    grant_id_d        = '0;
                    rr_ptr_d[level_q] = grant_id_q + 1'b1;
                    // a simultaneous done takes precedence over withdrawal
                    release_d         = withdraw && !arb_if.i_done;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_hclk or negedge i_hnreset) begin
        if (!i_hnreset) begin
            state_q       <= ARB_IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            release_q     <= 1'b0;
            level_q       <= PRIO_LOW;
            for (int unsigned p = 0; p < N_LEVELS; p++) begin
                rr_ptr_q[p] <= '0;
            end
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            release_q     <= release_d;
            level_q       <= level_d;
            for (int unsigned p = 0; p < N_LEVELS; p++) begin
                rr_ptr_q[p] <= rr_ptr_d[p];
            end
        end
    end

    assign arb_if.o_grant       = grant_q;
    assign arb_if.o_grant_valid = grant_valid_q;
    assign arb_if.o_grant_id    = grant_id_q;
    assign arb_if.o_release     = release_q;

endmodule

// File: tb/tb_dma_stream_arbiter.sv
// Directed bench for dma_stream_arbiter with hand-computed grant sequences.
module tb_dma_stream_arbiter;
    import dma_pkg::*;

    logic i_hclk;
    logic i_hnreset;
    int   n_checks;
    int   n_errors;

    dma_stream_arbiter_if arb_if ();

    dma_stream_arbiter u_dut (
        .i_hclk    (i_hclk),
        .i_hnreset (i_hnreset),
        .arb_if    (arb_if)
    );

    initial i_hclk = 1'b0;
    always #5 i_hclk = ~i_hclk;

    always @(posedge i_hclk) begin
        if (i_hnreset) begin
            assert (!(arb_if.i_done && !arb_if.o_grant_valid))
                else $error("protocol error: i_done while idle");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_hclk);
        #1;
    endtask

    task automatic check_grant(input string tag, input int id);
        check({tag, "_id"},    16'(arb_if.o_grant_id), 16'(id));
        check({tag, "_grant"}, 16'(arb_if.o_grant), 16'(8'(1) << id));
        check({tag, "_valid"}, 16'(arb_if.o_grant_valid), 16'd1);
    endtask

    task automatic check_idle(input string tag, input logic rel);
        check({tag, "_grant"},   16'(arb_if.o_grant), 16'd0);
        check({tag, "_valid"},   16'(arb_if.o_grant_valid), 16'd0);
        check({tag, "_id"},      16'(arb_if.o_grant_id), 16'd0);
        check({tag, "_release"}, 16'(arb_if.o_release), 16'(rel));
    endtask

    task automatic do_reset();
        arb_if.i_req  = '0;
        arb_if.i_prio = '0;
        arb_if.i_done = 1'b0;
        i_hnreset     = 1'b0;
        tick();
        tick();
        i_hnreset = 1'b1;
        tick();
    endtask

    // Pulse done for one cycle, check the bubble, then check the next grant.
    task automatic done_then_grant(input string tag, input int id);
        arb_if.i_done = 1'b1;
        tick();
        arb_if.i_done = 1'b0;
        check_idle({tag, "_bubble"}, 1'b0);
        tick();
        check_grant(tag, id);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        arb_if.i_req  = '0;
        arb_if.i_prio = '0;
        arb_if.i_done = 1'b0;
        i_hnreset     = 1'b0;
        #12;
        check_idle("in_reset", 1'b0);
        i_hnreset = 1'b1;
        tick();
        tick();
        check_idle("idle_noreq", 1'b0);

        // Single request, latency one cycle
        arb_if.i_req = 8'h01;
        tick();
        check_grant("single", 0);

        // Priority then round-robin within level 1
        do_reset();
        arb_if.i_prio = (16'(PRIO_MED) << 4) | (16'(PRIO_MED) << 10) | (16'(PRIO_VHIGH) << 12);
        arb_if.i_req  = 8'h64;
        tick();
        check_grant("prio_first", 6);
        arb_if.i_req = 8'h24;
        done_then_grant("prio_s2", 2);
        done_then_grant("prio_s5", 5);
        done_then_grant("prio_s2b", 2);

        // Four equal-priority streams with persistent requests
        do_reset();
        arb_if.i_req = 8'h9A;
        tick();
        check_grant("rr_1", 1);
        done_then_grant("rr_3", 3);
        done_then_grant("rr_4", 4);
        done_then_grant("rr_7", 7);
        done_then_grant("rr_1b", 1);

        // Withdrawal without done: release pulse, pointer advances to 4
        do_reset();
        arb_if.i_prio = 16'(PRIO_HIGH) << 6;
        arb_if.i_req  = 8'h08;
        tick();
        check_grant("wd_grant", 3);
        arb_if.i_req = 8'h00;
        tick();
        check_idle("wd_release", 1'b1);
        tick();
        check_idle("wd_after", 1'b0);
        arb_if.i_prio = (16'(PRIO_HIGH) << 6) | (16'(PRIO_HIGH) << 8);
        arb_if.i_req  = 8'h18;
        tick();
        check_grant("wd_ptr4", 4);

        // Done and withdrawal together: no release pulse
        arb_if.i_done = 1'b1;
        arb_if.i_req  = 8'h00;
        tick();
        arb_if.i_done = 1'b0;
        check_idle("both", 1'b0);
        tick();
        check_idle("both_after", 1'b0);

        // Priority change mid-BUSY, plus higher-level requester: no effect on held grant
        arb_if.i_prio = '0;
        arb_if.i_req  = 8'h02;
        tick();
        check_grant("pc_grant", 1);
        arb_if.i_prio = 16'(PRIO_VHIGH) << 2;
        tick();
        check_grant("pc_hold", 1);
        arb_if.i_prio = (16'(PRIO_VHIGH) << 2) | 16'(PRIO_VHIGH);
        arb_if.i_req  = 8'h03;
        tick();
        check_grant("pc_nopreempt", 1);
        arb_if.i_prio = '0;
        arb_if.i_req  = 8'h06;
        done_then_grant("pc_ptr_lvl0", 2);

        // Async reset while stream 7 is granted
        do_reset();
        arb_if.i_req = 8'h80;
        tick();
        check_grant("rst_grant7", 7);
        i_hnreset = 1'b0;
        #1;
        check_idle("rst_async", 1'b0);
        arb_if.i_req = 8'h81;
        #2;
        i_hnreset = 1'b1;
        tick();
        check_grant("rst_ptr0", 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
